tile_reset_sequencer: RTL and testbench
=======================================

// Module: tile_reset_sequencer
// PURPOSE
//  Sits downstream of the per-tile reset control register: takes its q bit and drives the tile.
//  The q bit is the software reset request; 1 = hold the tile in reset.
//  Produces a sequenced reset for one tile: quiesce handshake, clock gate, then a minimum-width
//  reset pulse, then a gated release. One instance per tile, in the tile's clock domain.
// PARAMETERS
//  SYNC_STAGES      2     synchronizer depth on io_req_reset (>=2)
//  HOLD_CYCLES      16    minimum cycles tile reset is held with clock running (>=1)
//  GATE_CYCLES      4     cycles the clock is gated around each reset edge (>=1)
//  QUIESCE_TIMEOUT  1024  cycles to wait for io_quiesce_ack before forcing reset (>=1)
//  CNT_W            11    counter width; must hold max(HOLD,GATE,QUIESCE_TIMEOUT)
// PORTS
//  clock            in   1  tile clock
//  reset            in   1  asynchronous, active-low reset (0 = in reset)
//  io_req_reset     in   1  reset request from control register q (may be async to clock)
//  io_quiesce_ack   in   1  tile reports it has drained outstanding traffic
//  io_quiesce_req   out  1  request tile to drain; held until ack, timeout or abort
//  io_clock_en      out  1  enable to tile clock gate
//  io_tile_reset    out  1  active-high reset to tile
//  io_in_reset      out  1  status: 1 whenever state != RUN
//  io_timeout       out  1  sticky: last quiesce ended by timeout
// BEHAVIOUR
//  - All outputs are registered.
//  - On reset low: outputs asynchronously go to
//      state=ASSERT, tile_reset=1, clock_en=1, quiesce_req=0, in_reset=1,
//      timeout=0, cnt=0, sync chain=0.
//  - io_req_reset passes through a SYNC_STAGES flop chain -> req_s.
//  - A single counter cnt is cleared on every state transition and increments otherwise.
//  - States:
//    RUN      tile_reset=0 clock_en=1. req_s=1 -> QUIESCE (quiesce_req=1 same edge).
//    QUIESCE  quiesce_req=1.
//             Priority: abort > ack > timeout.
//             req_s=0 -> RUN (abort; drop req; timeout unchanged).
//             else ack=1 -> GATE_OFF (timeout<=0).
//             else cnt==QUIESCE_TIMEOUT-1 -> GATE_OFF (timeout<=1).
//    GATE_OFF clock_en=0, quiesce_req=0, tile_reset=0.
//             cnt==GATE_CYCLES-1 -> ASSERT.
//    ASSERT   tile_reset=1, clock_en=1.
//             Leave only when cnt>=HOLD_CYCLES-1 AND req_s=0 -> PRE_REL.
//             cnt saturates at HOLD_CYCLES-1 (no wrap) while req_s stays 1.
//    PRE_REL  clock_en=0, tile_reset=1.
//             cnt==GATE_CYCLES-1 -> UNGATE.
//    UNGATE   clock_en=0, tile_reset=0.
//             cnt==GATE_CYCLES-1 -> RUN (clock_en=1).
//  - Latency:
//    io_req_reset rise to quiesce_req=1 is SYNC_STAGES+1 cycles.
//    After deassertion of reset with req_s=0, RUN is reached after HOLD_CYCLES+2*GATE_CYCLES cycles.
//  - Requests during GATE_OFF/PRE_REL/UNGATE are not aborted: the sequence completes.
//    A still-high req_s in RUN restarts the sequence at QUIESCE.
//  - Simultaneous abort and ack in QUIESCE: abort wins.
//  - quiesce_ack outside QUIESCE is ignored.
//  - The timeout flag changes only on QUIESCE exit via ack or timeout.
//  - Reset low in any state forces ASSERT immediately; no quiesce is performed.
// TESTING
//  - Power-up (defaults): release reset, req=0 -> tile_reset=1 for 16 cycles, then clock_en=0
//    for 8 cycles (tile_reset falls after 4 of them), then RUN with clock_en=1, in_reset=0.
//  - Normal: req 0->1, ack 3 cycles after quiesce_req -> GATE_OFF 4 cyc, ASSERT;
//    req->0 at cycle 40 -> PRE_REL 4, UNGATE 4, RUN; timeout=0.
//  - Timeout: QUIESCE_TIMEOUT=8, ack held 0 -> GATE_OFF after exactly 8 QUIESCE cycles;
//    timeout=1 until next ack-terminated quiesce.
//  - Abort: req pulse that keeps req_s high for 5 cycles, no ack -> quiesce_req for those cycles,
//    then RUN; tile_reset never asserts, clock_en never drops.
//  - Short request: req_s high only 2 cycles inside ASSERT -> tile_reset stays high the full 16 cycles.
//  - Mid-sequence reset: drive reset low during UNGATE -> tile_reset=1, clock_en=1 asynchronously;
//    full power-up sequence follows after release.

Source files
------------

// File: rtl/tile_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tile_reset_sequencer                                         |
// | Description : Per-tile reset sequencer. Turns the software reset request   |
// |               into a quiesce handshake, clock gate, minimum-width reset    |
// |               pulse and gated release. Lives in the tile clock domain.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tile_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int GATE_CYCLES     = 4,
    parameter int QUIESCE_TIMEOUT = 1024,
    parameter int CNT_W           = 11
) (
    input  logic clock,
    input  logic reset,
    input  logic io_req_reset,
    input  logic io_quiesce_ack,
    output logic io_quiesce_req,
    output logic io_clock_en,
    output logic io_tile_reset,
    output logic io_in_reset,
    output logic io_timeout
);

    localparam logic [2:0] c_st_run      = 3'd0;
    localparam logic [2:0] c_st_quiesce  = 3'd1;
    localparam logic [2:0] c_st_gate_off = 3'd2;
    localparam logic [2:0] c_st_assert   = 3'd3;
    localparam logic [2:0] c_st_pre_rel  = 3'd4;
    localparam logic [2:0] c_st_ungate   = 3'd5;

    localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gate_last    = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_quiesce_last = CNT_W'(QUIESCE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_timeout_nxt;
    logic                   w_quiesce_req_nxt;
    logic                   w_clock_en_nxt;
    logic                   w_tile_reset_nxt;
    logic                   w_in_reset_nxt;

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // Bring the (possibly asynchronous) request into the tile clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], io_req_reset};
        end
    end

    // Next state, phase counter and output decode of the state being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_nxt = io_timeout;

        case (r_state)
            c_st_run: begin
                if (w_req_s) w_state_nxt = c_st_quiesce;
            end
            c_st_quiesce: begin
                // Abort beats ack beats timeout.
                if (!w_req_s) begin
                    w_state_nxt = c_st_run;
                end else if (io_quiesce_ack) begin
                    w_state_nxt   = c_st_gate_off;
                    w_timeout_nxt = 1'b0;
                end else if (r_cnt == c_quiesce_last) begin
                    w_state_nxt   = c_st_gate_off;
                    w_timeout_nxt = 1'b1;
                end
            end
            c_st_gate_off: begin
                if (r_cnt == c_gate_last) w_state_nxt = c_st_assert;
            end
            c_st_assert: begin
                if (r_cnt >= c_hold_last && !w_req_s) w_state_nxt = c_st_pre_rel;
            end
            c_st_pre_rel: begin
                if (r_cnt == c_gate_last) w_state_nxt = c_st_ungate;
            end
            c_st_ungate: begin
                if (r_cnt == c_gate_last) w_state_nxt = c_st_run;
            end
            default: begin
                w_state_nxt = c_st_assert;
            end
        endcase

        // Counter restarts on every transition; parks at the hold limit while
        // the request keeps the tile in reset so it never wraps back below it.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_state == c_st_assert && r_cnt >= c_hold_last) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        // Outputs are registered from the state being entered so they change
        // on the same edge as the state.
        w_quiesce_req_nxt = (w_state_nxt == c_st_quiesce);
        w_clock_en_nxt    = !((w_state_nxt == c_st_gate_off) ||
                              (w_state_nxt == c_st_pre_rel)  ||
                              (w_state_nxt == c_st_ungate));
        w_tile_reset_nxt  = (w_state_nxt == c_st_assert) || (w_state_nxt == c_st_pre_rel);
        w_in_reset_nxt    = (w_state_nxt != c_st_run);
    end

    // State, counter and registered outputs; reset forces the tile into reset at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= c_st_assert;
            r_cnt          <= '0;
            io_quiesce_req <= 1'b0;
            io_clock_en    <= 1'b1;
            io_tile_reset  <= 1'b1;
            io_in_reset    <= 1'b1;
            io_timeout     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            io_quiesce_req <= w_quiesce_req_nxt;
            io_clock_en    <= w_clock_en_nxt;
            io_tile_reset  <= w_tile_reset_nxt;
            io_in_reset    <= w_in_reset_nxt;
            io_timeout     <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tile_reset_sequencer                                      |
// | Description : Self-checking bench for tile_reset_sequencer: phase-level    |
// |               model compared every cycle plus directed literal checks.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tile_reset_sequencer;

    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int GATE = 4;
    localparam int QTO  = 8;
    localparam int CW   = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic req   = 1'b0;
    logic ack   = 1'b0;
    logic qreq, ce, tr, inr, tmo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tile_reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .HOLD_CYCLES    (HOLD),
        .GATE_CYCLES    (GATE),
        .QUIESCE_TIMEOUT(QTO),
        .CNT_W          (CW)
    ) u_dut (
        .clock         (clk),
        .reset         (rst_n),
        .io_req_reset  (req),
        .io_quiesce_ack(ack),
        .io_quiesce_req(qreq),
        .io_clock_en   (ce),
        .io_tile_reset (tr),
        .io_in_reset   (inr),
        .io_timeout    (tmo)
    );

    // Phase-level model: which phase the tile is in and how long it has been there.
    localparam int P_RUN   = 0;
    localparam int P_DRAIN = 1;
    localparam int P_GOFF  = 2;
    localparam int P_HOLD  = 3;
    localparam int P_PRE   = 4;
    localparam int P_UNG   = 5;

    int            m_phase = P_HOLD;
    int            m_elapsed = 0;
    int            m_nxt;
    logic          m_tmo = 1'b0;
    logic          m_rs;
    logic [SYNC-1:0] m_hist = '0;

    function automatic logic [4:0] exp_out(input int ph, input logic t);
        logic q, c, r, i;
        q = (ph == P_DRAIN);
        c = !(ph == P_GOFF || ph == P_PRE || ph == P_UNG);
        r = (ph == P_HOLD || ph == P_PRE);
        i = (ph != P_RUN);
        return {q, c, r, i, t};
    endfunction

    // Advance the model one cycle; reset drops it straight into the hold phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   = P_HOLD;
            m_elapsed = 0;
            m_tmo     = 1'b0;
            m_hist    = '0;
        end else begin
            m_rs      = m_hist[SYNC-1];
            m_nxt     = m_phase;
            m_elapsed = m_elapsed + 1;
            case (m_phase)
                P_RUN:   if (m_rs) m_nxt = P_DRAIN;
                P_DRAIN: begin
                    if (!m_rs) m_nxt = P_RUN;
                    else if (ack) begin m_nxt = P_GOFF; m_tmo = 1'b0; end
                    else if (m_elapsed == QTO) begin m_nxt = P_GOFF; m_tmo = 1'b1; end
                end
                P_GOFF:  if (m_elapsed == GATE) m_nxt = P_HOLD;
                P_HOLD:  if (m_elapsed >= HOLD && !m_rs) m_nxt = P_PRE;
                P_PRE:   if (m_elapsed == GATE) m_nxt = P_UNG;
                P_UNG:   if (m_elapsed == GATE) m_nxt = P_RUN;
                default: m_nxt = P_HOLD;
            endcase
            if (m_nxt != m_phase) m_elapsed = 0;
            m_phase = m_nxt;
            m_hist  = {m_hist[SYNC-2:0], req};
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        n_vec++;
        if ({qreq, ce, tr, inr, tmo} !== exp_out(m_phase, m_tmo)) begin
            n_err++;
            $display("FAIL model_cycle t=%0t: qreq/ce/tr/inr/tmo got %b expected %b",
                     $time, {qreq, ce, tr, inr, tmo}, exp_out(m_phase, m_tmo));
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // Negedges until in_reset drops, bounded.
    task automatic wait_for_run(input int budget, output int k);
        k = 0;
        while (inr !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("reach_run", int'(inr), 0);
    endtask

    // Release reset at a negedge and measure the power-up sequence shape.
    task automatic powerup_measure(input string tag, input bit pulse);
        int nh, ng, ngt, krun;
        nh = 0; ng = 0; ngt = 0; krun = -1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (tr === 1'b1 && ce === 1'b1) nh++;
            if (ce === 1'b0) ng++;
            if (ce === 1'b0 && tr === 1'b1) ngt++;
            if (inr === 1'b0 && krun < 0) krun = i;
            if (pulse && i == 3) req = 1'b1;
            if (pulse && i == 5) req = 1'b0;
        end
        chk({tag, "_hold_cycles"}, nh, 16);
        chk({tag, "_gated_cycles"}, ng, 8);
        chk({tag, "_gated_in_reset"}, ngt, 4);
        chk({tag, "_cycles_to_run"}, krun, 24);
    endtask

    initial begin
        int k, k2, n, nq, bad;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_tile_reset", int'(tr), 1);
        chk("reset_clock_en", int'(ce), 1);
        chk("reset_quiesce_req", int'(qreq), 0);
        chk("reset_in_reset", int'(inr), 1);
        chk("reset_timeout", int'(tmo), 0);
        repeat (3) @(negedge clk);

        // Power-up
        powerup_measure("powerup", 1'b0);

        // Normal request with ack three cycles after quiesce_req
        req = 1'b1; k = 0;
        while (qreq !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        chk("req_to_quiesce_latency", k, 3);
        repeat (3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("gate_off_clock_en", int'(ce), 0);
        chk("gate_off_tile_reset", int'(tr), 0);
        repeat (4) @(negedge clk);
        chk("assert_tile_reset", int'(tr), 1);
        chk("assert_clock_en", int'(ce), 1);
        repeat (29) @(negedge clk);
        req = 1'b0;
        wait_for_run(30, k2);
        chk("release_to_run", k2, 11);
        chk("normal_timeout_flag", int'(tmo), 0);

        // Quiesce timeout with ack held low
        req = 1'b1;
        repeat (3) @(negedge clk);
        n = 0;
        while (qreq === 1'b1 && n < 20) begin n++; @(negedge clk); end
        chk("timeout_quiesce_cycles", n, 8);
        chk("timeout_flag_set", int'(tmo), 1);
        chk("timeout_gate_off_clock_en", int'(ce), 0);
        req = 1'b0;
        wait_for_run(80, k2);
        chk("timeout_release_to_run", k2, 28);
        chk("timeout_flag_held", int'(tmo), 1);

        // Abort: req_s high for 5 cycles, no ack
        req = 1'b1; nq = 0; bad = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (qreq === 1'b1) nq++;
            if (tr !== 1'b0 || ce !== 1'b1) bad++;
            if (i == 5) req = 1'b0;
        end
        chk("abort_quiesce_cycles", nq, 5);
        chk("abort_no_reset_no_gate", bad, 0);
        chk("abort_timeout_unchanged", int'(tmo), 1);
        chk("abort_back_in_run", int'(inr), 0);

        // Ack-terminated quiesce clears the flag, then reset lands in UNGATE
        req = 1'b1; k = 0;
        while (qreq !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; req = 1'b0;
        chk("ack_clears_timeout", int'(tmo), 0);
        k = 0;
        while (tr !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (!(ce === 1'b0 && tr === 1'b0) && k < 40) begin @(negedge clk); k++; end
        chk("reached_ungate", int'(ce === 1'b0 && tr === 1'b0 && inr === 1'b1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_tile_reset", int'(tr), 1);
        chk("midreset_clock_en", int'(ce), 1);
        chk("midreset_in_reset", int'(inr), 1);
        repeat (2) @(negedge clk);

        // Post-reset power-up with a short request inside ASSERT
        powerup_measure("shortreq", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
